pll_reset_sequencer: RTL and testbench
======================================

# pll_reset_sequencer

Sequences bring-up of the iCE40 PLL and the system reset derived from it. Runs on the board reference clock (24 MHz): holds the PLL in reset, waits for lock with timeout and bounded retry, then requires lock to stay stable before releasing the system reset. Any lock loss re-asserts the system reset and restarts the sequence. Sits between the board reset pin, the PLL wrapper (`RESETB`/`LOCK`) and every reset synchronizer in the 48 MHz domain.

## Interface
Parameters:
- `PLL_RESET_CYCLES`, 16: cycles `pll_resetb` is held low per attempt (≥2)
- `LOCK_TIMEOUT`, 4800: cycles to wait for lock per attempt (200 µs)
- `STABLE_CYCLES`, 2400: cycles lock must stay continuously high before release (100 µs)
- `MAX_RETRIES`, 3: extra attempts after the first timeout before faulting
- `LOSS_CNT_W`, 8: width of lock-loss counter

Ports:
- `clock` in 1: reference clock, all logic on rising edge
- `resetb` in 1: asynchronous, active-low reset
- `locked` in 1: raw PLL lock, asynchronous to `clock`
- `restart` in 1: synchronous single-cycle request to rerun the sequence
- `pll_resetb` out 1: to PLL `RESETB`; low = PLL held in reset
- `sys_resetb` out 1: system reset, active-low
- `ready` out 1: high only in RUN
- `fault` out 1: high only in FAULT
- `lock_loss_count` out LOSS_CNT_W: saturating count of RUN→lock-loss events
- `state` out 3: current state encoding

## Operation
- `locked` passes through a 2-flop synchronizer (reset to 0) → `locked_s`.
- One timer; cleared on every state change. Widths: `$clog2(max(PLL_RESET_CYCLES,LOCK_TIMEOUT,STABLE_CYCLES))`, retry counter `$clog2(MAX_RETRIES+1)`.
- States (encoding): PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAULT=4.
- PLL_RST: `pll_resetb`=0. After exactly PLL_RESET_CYCLES cycles (timer == N−1) → WAIT_LOCK.
- WAIT_LOCK: `pll_resetb`=1. `locked_s`=1 → STABLE. Else timer == LOCK_TIMEOUT−1: retries < MAX_RETRIES → retries+1, PLL_RST; otherwise → FAULT.
- STABLE: `locked_s`=0 → WAIT_LOCK (timer cleared, retries unchanged). Timer == STABLE_CYCLES−1 with lock held → RUN, retries cleared.
- RUN: `sys_resetb`=1, `ready`=1. `locked_s`=0 → PLL_RST, `lock_loss_count`+1 (saturates at all-ones).
- FAULT: `pll_resetb`=1, `sys_resetb`=0; terminal until `restart` or `resetb`.
- `restart` in any state → PLL_RST, timer and retries cleared; has priority over all other transitions; `lock_loss_count` preserved.
- `sys_resetb`=0 in every state except RUN.
- Reset values: state PLL_RST, `pll_resetb`=0, `sys_resetb`=0, `ready`=0, `fault`=0, `lock_loss_count`=0, `state`=0, timer/retries 0.

## Timing
- All outputs registered; they change on the same edge as the state register.
- `locked` edge → `locked_s` after 2 edges → state change on the 3rd edge.
- Lock present throughout: `sys_resetb` rises PLL_RESET_CYCLES + 1 + STABLE_CYCLES edges after `resetb` deassertion.
- Lock loss in RUN: `sys_resetb` falls 3 edges after `locked` falls.
- `resetb` assertion forces reset values immediately, mid-sequence included; `sys_resetb` deasserts only synchronously to `clock`. Consumers in the PLL domain resynchronize it.

## Configuration
- `PLL_SEQ_DIAG_EN` defined: `lock_loss_count` counter and `state` output implemented as above.
- Not defined: counter logic removed; `lock_loss_count` and `state` driven constant 0; sequencing unchanged.

## Structure
- Package `pll_seq_pkg`: state enum typedef `pll_seq_state_t` with the encodings above, and the `STATE_W`=3 constant.
- Sub-module `sync_ff2`: 2-flop synchronizer with asynchronous active-low reset to 0. The FSM, timer and counters stay in the top module.

## Test plan
Use PLL_RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- `locked` tied 1, release `resetb` → `pll_resetb` rises at edge 4, `sys_resetb`/`ready` rise at edge 13.
- `locked` tied 0 → three PLL_RST pulses of 4 cycles each, then `fault`=1 at edge 72; `sys_resetb` stays 0.
- In STABLE, drop `locked` for 1 cycle at timer=5 → return to WAIT_LOCK, then full 8-cycle STABLE before RUN; retries unchanged.
- In RUN, drop `locked` → `sys_resetb`=0 3 edges later, state PLL_RST, `lock_loss_count`=1; repeat 300 times with LOSS_CNT_W=8 → count saturates at 255.
- In FAULT, pulse `restart` → PLL_RST next edge; with `locked`=1 → RUN 13 edges after restart. Assert `resetb` mid-STABLE → all outputs return to reset values immediately.
- Build without `PLL_SEQ_DIAG_EN` → `state`/`lock_loss_count` stay 0; the first two scenarios still pass.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and a small
// constant helper used to size the shared timer.
package pll_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } pll_seq_state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_ff2 (
   input  logic i_clock,
   input  logic i_resetb,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clock or negedge i_resetb) begin
      if (!i_resetb) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and system reset sequencer on the reference clock.
// Define PLL_SEQ_DIAG_EN to build the lock-loss counter and state output.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RESET_CYCLES = 16,
   parameter int LOCK_TIMEOUT     = 4800,
   parameter int STABLE_CYCLES    = 2400,
   parameter int MAX_RETRIES      = 3,
   parameter int LOSS_CNT_W       = 8
) (
   input  logic                  clock,
   input  logic                  resetb,
   input  logic                  locked,
   input  logic                  restart,
   output logic                  pll_resetb,
   output logic                  sys_resetb,
   output logic                  ready,
   output logic                  fault,
   output logic [LOSS_CNT_W-1:0] lock_loss_count,
   output logic [STATE_W-1:0]    state
);

   localparam int TMR_W = $clog2(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));
   localparam int RTY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   pll_seq_state_t   r_state;
   pll_seq_state_t   w_state_nxt;
   logic [TMR_W-1:0] r_timer;
   logic [TMR_W-1:0] w_timer_nxt;
   logic [RTY_W-1:0] r_retries;
   logic [RTY_W-1:0] w_retries_nxt;
   logic             r_pll_resetb;
   logic             r_run;
   logic             r_fault;
   logic             w_locked_s;

   sync_ff2 u_lock_sync (
      .i_clock  (clock),
      .i_resetb (resetb),
      .i_d      (locked),
      .o_q      (w_locked_s)
   );

   // Restart overrides every state; the timer restarts from 0 on each state change.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer + TMR_W'(1);
      w_retries_nxt = r_retries;
      if (restart) begin
         w_state_nxt   = PLL_RST;
         w_timer_nxt   = '0;
         w_retries_nxt = '0;
      end else begin
         case (r_state)
            PLL_RST: begin
               if (r_timer == TMR_W'(PLL_RESET_CYCLES - 1)) begin
                  w_state_nxt = WAIT_LOCK;
                  w_timer_nxt = '0;
               end
            end
            WAIT_LOCK: begin
               if (w_locked_s) begin
                  w_state_nxt = STABLE;
                  w_timer_nxt = '0;
               end else if (r_timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
                  w_timer_nxt = '0;
                  if (r_retries < RTY_W'(MAX_RETRIES)) begin
                     w_retries_nxt = r_retries + RTY_W'(1);
                     w_state_nxt   = PLL_RST;
                  end else begin
                     w_state_nxt = FAULT;
                  end
               end
            end
            STABLE: begin
               if (!w_locked_s) begin
                  w_state_nxt = WAIT_LOCK;
                  w_timer_nxt = '0;
               end else if (r_timer == TMR_W'(STABLE_CYCLES - 1)) begin
                  w_state_nxt   = RUN;
                  w_timer_nxt   = '0;
                  w_retries_nxt = '0;
               end
            end
            RUN: begin
               w_timer_nxt = '0;
               if (!w_locked_s) begin
                  w_state_nxt = PLL_RST;
               end
            end
            FAULT: begin
               w_timer_nxt = '0;
            end
            default: begin
               w_state_nxt   = PLL_RST;
               w_timer_nxt   = '0;
               w_retries_nxt = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they switch on the same edge as r_state.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state      <= PLL_RST;
         r_timer      <= '0;
         r_retries    <= '0;
         r_pll_resetb <= 1'b0;
         r_run        <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_retries    <= w_retries_nxt;
         r_pll_resetb <= (w_state_nxt != PLL_RST);
         r_run        <= (w_state_nxt == RUN);
         r_fault      <= (w_state_nxt == FAULT);
      end
   end

   assign pll_resetb = r_pll_resetb;
   assign sys_resetb = r_run;
   assign ready      = r_run;
   assign fault      = r_fault;

`ifdef PLL_SEQ_DIAG_EN
   logic [LOSS_CNT_W-1:0] r_loss_cnt;
   logic                  w_loss_evt;

   assign w_loss_evt = !restart && (r_state == RUN) && !w_locked_s;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_loss_cnt <= '0;
      end else if (w_loss_evt && (r_loss_cnt != {LOSS_CNT_W{1'b1}})) begin
         r_loss_cnt <= r_loss_cnt + LOSS_CNT_W'(1);
      end
   end

   assign lock_loss_count = r_loss_cnt;
   assign state           = r_state;
`else
   assign lock_loss_count = '0;
   assign state           = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Expected diagnostic values follow PLL_SEQ_DIAG_EN (zero when undefined).
module tb_pll_reset_sequencer;

`ifdef PLL_SEQ_DIAG_EN
   localparam bit DIAG = 1'b1;
`else
   localparam bit DIAG = 1'b0;
`endif

   logic       clock;
   logic       resetb;
   logic       locked;
   logic       restart;
   logic       pll_resetb;
   logic       sys_resetb;
   logic       ready;
   logic       fault;
   logic [7:0] lock_loss_count;
   logic [2:0] state;

   int checks;
   int errors;

   pll_reset_sequencer #(
      .PLL_RESET_CYCLES (4),
      .LOCK_TIMEOUT     (20),
      .STABLE_CYCLES    (8),
      .MAX_RETRIES      (2),
      .LOSS_CNT_W       (8)
   ) dut (
      .clock           (clock),
      .resetb          (resetb),
      .locked          (locked),
      .restart         (restart),
      .pll_resetb      (pll_resetb),
      .sys_resetb      (sys_resetb),
      .ready           (ready),
      .fault           (fault),
      .lock_loss_count (lock_loss_count),
      .state           (state)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [2:0] exp_st(input logic [2:0] s);
      return DIAG ? s : 3'd0;
   endfunction

   function automatic logic [7:0] exp_cnt(input logic [7:0] c);
      return DIAG ? c : 8'd0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Leaves the bench just after a falling edge with reset released, so the
   // next rising edge is edge 1 of the sequence.
   task automatic do_reset(input logic lock_val);
      resetb  = 1'b0;
      locked  = lock_val;
      restart = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetb = 1'b1;
   endtask

   task automatic wait_run(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         tick(1);
         if (ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      resetb = 1'b0; locked = 1'b0; restart = 1'b0;
      tick(2);
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll_resetb: got %b want 0", pll_resetb); end
      checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL reset_sys_resetb: got %b want 0", sys_resetb); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", fault); end
      checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", lock_loss_count); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
   endtask

   task automatic test_lock_present;
      do_reset(1'b1);
      for (int e = 1; e <= 13; e++) begin
         tick(1);
         if (e == 3) begin
            checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL lock_pll_resetb_e3: got %b want 0", pll_resetb); end
         end
         if (e == 4) begin
            checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL lock_pll_resetb_e4: got %b want 1", pll_resetb); end
            checks++; if (state !== exp_st(3'd1)) begin errors++; $display("FAIL lock_state_e4: got %0d want %0d", state, exp_st(3'd1)); end
         end
         if (e == 5) begin
            checks++; if (state !== exp_st(3'd2)) begin errors++; $display("FAIL lock_state_e5: got %0d want %0d", state, exp_st(3'd2)); end
         end
         if (e == 12) begin
            checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL lock_sys_resetb_e12: got %b want 0", sys_resetb); end
            checks++; if (ready !== 1'b0) begin errors++; $display("FAIL lock_ready_e12: got %b want 0", ready); end
         end
         if (e == 13) begin
            checks++; if (sys_resetb !== 1'b1) begin errors++; $display("FAIL lock_sys_resetb_e13: got %b want 1", sys_resetb); end
            checks++; if (ready !== 1'b1) begin errors++; $display("FAIL lock_ready_e13: got %b want 1", ready); end
            checks++; if (state !== exp_st(3'd3)) begin errors++; $display("FAIL lock_state_e13: got %0d want %0d", state, exp_st(3'd3)); end
         end
      end
   endtask

   task automatic test_lock_loss;
      tick(2);
      locked = 1'b0;
      tick(2);
      checks++; if (sys_resetb !== 1'b1) begin errors++; $display("FAIL loss_sys_resetb_e2: got %b want 1", sys_resetb); end
      tick(1);
      checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL loss_sys_resetb_e3: got %b want 0", sys_resetb); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL loss_ready_e3: got %b want 0", ready); end
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_pll_resetb_e3: got %b want 0", pll_resetb); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL loss_state_e3: got %0d want 0", state); end
      checks++; if (lock_loss_count !== exp_cnt(8'd1)) begin errors++; $display("FAIL loss_count: got %0d want %0d", lock_loss_count, exp_cnt(8'd1)); end
   endtask

   task automatic test_restart_in_run;
      bit ok;
      locked = 1'b1;
      wait_run(40, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rrun_relock: got ready=%b want 1 within 40 cycles", ready); end
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rrun_pll_resetb: got %b want 0", pll_resetb); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rrun_ready: got %b want 0", ready); end
      checks++; if (lock_loss_count !== exp_cnt(8'd1)) begin errors++; $display("FAIL rrun_count_kept: got %0d want %0d", lock_loss_count, exp_cnt(8'd1)); end
      tick(12);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rrun_ready_r12: got %b want 0", ready); end
      tick(1);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rrun_ready_r13: got %b want 1", ready); end
   endtask

   task automatic test_saturate;
      bit ok;
      int timeouts;
      timeouts = 0;
      for (int i = 2; i <= 300; i++) begin
         locked = 1'b0;
         tick(3);
         if (i == 254 || i == 255 || i == 256 || i == 300) begin
            logic [7:0] want;
            want = (i >= 255) ? 8'd255 : 8'(i);
            checks++; if (lock_loss_count !== exp_cnt(want)) begin errors++; $display("FAIL sat_count_%0d: got %0d want %0d", i, lock_loss_count, exp_cnt(want)); end
         end
         locked = 1'b1;
         wait_run(30, ok);
         if (!ok) timeouts++;
      end
      checks++; if (timeouts != 0) begin errors++; $display("FAIL sat_relock_timeouts: got %0d want 0", timeouts); end
   endtask

   task automatic test_reset_mid_stable;
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      tick(7);
      checks++; if (state !== exp_st(3'd2)) begin errors++; $display("FAIL mid_pre_state: got %0d want %0d", state, exp_st(3'd2)); end
      checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL mid_pre_pll_resetb: got %b want 1", pll_resetb); end
      #2;
      resetb = 1'b0;
      #1;
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL mid_pll_resetb: got %b want 0", pll_resetb); end
      checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL mid_sys_resetb: got %b want 0", sys_resetb); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b want 0", ready); end
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL mid_fault: got %b want 0", fault); end
      checks++; if (lock_loss_count !== 8'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", lock_loss_count); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL mid_state: got %0d want 0", state); end
   endtask

   task automatic test_timeout_fault;
      logic exp_pll;
      logic exp_fault;
      do_reset(1'b0);
      for (int e = 1; e <= 75; e++) begin
         tick(1);
         exp_pll   = !((e < 4) || (e >= 24 && e < 28) || (e >= 48 && e < 52));
         exp_fault = (e >= 72);
         checks++; if (pll_resetb !== exp_pll) begin errors++; $display("FAIL tmo_pll_resetb_e%0d: got %b want %b", e, pll_resetb, exp_pll); end
         checks++; if (fault !== exp_fault) begin errors++; $display("FAIL tmo_fault_e%0d: got %b want %b", e, fault, exp_fault); end
         checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL tmo_sys_resetb_e%0d: got %b want 0", e, sys_resetb); end
         if (e == 72) begin
            checks++; if (state !== exp_st(3'd4)) begin errors++; $display("FAIL tmo_state_e72: got %0d want %0d", state, exp_st(3'd4)); end
         end
      end
   endtask

   task automatic test_restart_from_fault;
      locked = 1'b1;
      tick(4);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rflt_fault_held: got %b want 1", fault); end
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rflt_fault: got %b want 0", fault); end
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rflt_pll_resetb: got %b want 0", pll_resetb); end
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL rflt_state: got %0d want 0", state); end
      tick(12);
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rflt_ready_r12: got %b want 0", ready); end
      tick(1);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rflt_ready_r13: got %b want 1", ready); end
      checks++; if (sys_resetb !== 1'b1) begin errors++; $display("FAIL rflt_sys_resetb_r13: got %b want 1", sys_resetb); end
   endtask

   task automatic test_stable_glitch;
      do_reset(1'b1);
      tick(10);
      checks++; if (state !== exp_st(3'd2)) begin errors++; $display("FAIL glitch_pre_state: got %0d want %0d", state, exp_st(3'd2)); end
      locked = 1'b0;
      tick(1);
      locked = 1'b1;
      tick(2);
      checks++; if (state !== exp_st(3'd1)) begin errors++; $display("FAIL glitch_state_e13: got %0d want %0d", state, exp_st(3'd1)); end
      checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL glitch_sys_resetb_e13: got %b want 0", sys_resetb); end
      checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL glitch_pll_resetb_e13: got %b want 1", pll_resetb); end
      tick(1);
      checks++; if (state !== exp_st(3'd2)) begin errors++; $display("FAIL glitch_state_e14: got %0d want %0d", state, exp_st(3'd2)); end
      tick(7);
      checks++; if (sys_resetb !== 1'b0) begin errors++; $display("FAIL glitch_sys_resetb_e21: got %b want 0", sys_resetb); end
      tick(1);
      checks++; if (sys_resetb !== 1'b1) begin errors++; $display("FAIL glitch_sys_resetb_e22: got %b want 1", sys_resetb); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready_e22: got %b want 1", ready); end
   endtask

   task automatic test_stable_loss_retries;
      do_reset(1'b0);
      tick(24);
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rty_pll_resetb_e24: got %b want 0", pll_resetb); end
      locked = 1'b1;
      tick(5);
      checks++; if (state !== exp_st(3'd2)) begin errors++; $display("FAIL rty_state_e29: got %0d want %0d", state, exp_st(3'd2)); end
      tick(1);
      locked = 1'b0;
      tick(3);
      checks++; if (state !== exp_st(3'd1)) begin errors++; $display("FAIL rty_state_e33: got %0d want %0d", state, exp_st(3'd1)); end
      tick(19);
      checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL rty_pll_resetb_e52: got %b want 1", pll_resetb); end
      tick(1);
      checks++; if (pll_resetb !== 1'b0) begin errors++; $display("FAIL rty_pll_resetb_e53: got %b want 0", pll_resetb); end
      tick(23);
      checks++; if (fault !== 1'b0) begin errors++; $display("FAIL rty_fault_e76: got %b want 0", fault); end
      tick(1);
      checks++; if (fault !== 1'b1) begin errors++; $display("FAIL rty_fault_e77: got %b want 1", fault); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks  = 0;
      errors  = 0;
      resetb  = 1'b0;
      locked  = 1'b0;
      restart = 1'b0;
      test_reset;
      test_lock_present;
      test_lock_loss;
      test_restart_in_run;
      test_saturate;
      test_reset_mid_stable;
      test_timeout_fault;
      test_restart_from_fault;
      test_stable_glitch;
      test_stable_loss_retries;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
